// File: rtl/fpu_sequencer.sv
// fpu_sequencer: operand sequencer and result capture around a free-running FPU core.
//
// Operand pairs are taken in over a valid/ready handshake and buffered in a
// DEPTH-entry FIFO. Each pair is driven onto the FPU inputs and held for
// HOLD_CYCLES cycles, which covers two worst-case FPU computations. At the end
// of the hold, the FPU result and status are registered and presented
// downstream over a valid/ready handshake.
//
// Parameters:
//   DEPTH        operand FIFO entries (power of two, >= 2)
//   HOLD_CYCLES  cycles a pair is held before the result is sampled (>= 64)
//
// Ports:
//   clock100KHz            system clock
//   reset                  asynchronous active-low reset, shared with the FPU
//   in_valid/in_ready      operand handshake; in_a, in_b operand pair
//   fpu_op_a/fpu_op_b      operands driven to the FPU core
//   fpu_data/fpu_status    FPU result and status (1000 unf, 0100 ovf, 0010 inx, 0001 exact)
//   out_valid/out_ready    result handshake; out_data, out_status captured result
//   ovf_count, unf_count, inx_count
//                          saturating per-status counters of transferred results,
//                          present only when FPU_SEQ_STATS_EN is defined
//
// Optional feature macro: FPU_SEQ_STATS_EN
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a buffered pair; pops the FIFO head when present
// HOLD    | pair held on the FPU inputs while hold_cnt counts down
// PRESENT | captured result offered downstream until out_ready

module fpu_sequencer #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 64
) (
    input  logic        clock100KHz,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] fpu_op_a,
    output logic [31:0] fpu_op_b,
    input  logic [31:0] fpu_data,
    input  logic [3:0]  fpu_status,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_status
`ifdef FPU_SEQ_STATS_EN
   ,output logic [15:0] ovf_count,
    output logic [15:0] unf_count,
    output logic [15:0] inx_count
`endif
);

    localparam int            AW        = $clog2(DEPTH);
    localparam int            CW        = $clog2(HOLD_CYCLES);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t        state_q;
    logic [31:0]   mem_a_q [DEPTH];
    logic [31:0]   mem_b_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic [CW-1:0] hold_cnt_q;
    logic [31:0]   op_a_q;
    logic [31:0]   op_b_q;
    logic          out_valid_q;
    logic [31:0]   out_data_q;
    logic [3:0]    out_status_q;
    logic          push;
    logic          pop;

    // in_ready comes only from registered occupancy, never from in_valid.
    assign in_ready = (count_q != FULL_CNT);
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == IDLE) && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clock100KHz) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= in_a;
            mem_b_q[wr_ptr_q] <= in_b;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            hold_cnt_q   <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_status_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        op_a_q     <= mem_a_q[rd_ptr_q];
                        op_b_q     <= mem_b_q[rd_ptr_q];
                        hold_cnt_q <= HOLD_LOAD;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    // Capture lands HOLD_CYCLES edges after the pop edge.
                    if (hold_cnt_q == '0) begin
                        out_data_q   <= fpu_data;
                        out_status_q <= fpu_status;
                        out_valid_q  <= 1'b1;
                        state_q      <= PRESENT;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 1'b1;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fpu_op_a   = op_a_q;
    assign fpu_op_b   = op_b_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_status = out_status_q;

`ifdef FPU_SEQ_STATS_EN
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [15:0] ovf_cnt_q;
    logic [15:0] unf_cnt_q;
    logic [15:0] inx_cnt_q;
    logic        xfer;

    assign xfer = out_valid_q && out_ready;

    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            ovf_cnt_q <= '0;
            unf_cnt_q <= '0;
            inx_cnt_q <= '0;
        end else if (xfer) begin
            case (out_status_q)
                4'b0100: if (ovf_cnt_q != CNT_MAX) ovf_cnt_q <= ovf_cnt_q + 1'b1;
                4'b1000: if (unf_cnt_q != CNT_MAX) unf_cnt_q <= unf_cnt_q + 1'b1;
                4'b0010: if (inx_cnt_q != CNT_MAX) inx_cnt_q <= inx_cnt_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign ovf_count = ovf_cnt_q;
    assign unf_count = unf_cnt_q;
    assign inx_count = inx_cnt_q;
`endif

endmodule
